// File: rtl/sum_arbiter.sv
// rtl/sum_arbiter.sv - round-robin scheduler sharing one three-operand adder between requesters
module sum_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    input  logic [N_REQ*W-1:0] c_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       sum_a,
    output logic [W-1:0]       sum_b,
    output logic [W-1:0]       sum_c,
    input  logic [W+1:0]       sum_out,
    output logic               res_valid,
    output logic [W+1:0]       res_data,
    output logic [ID_W-1:0]    res_id,
    input  logic               res_ready,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;

    // First set request at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            gnt       <= '0;
            sum_a     <= '0;
            sum_b     <= '0;
            sum_c     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        sum_a      <= a_in[pick*W +: W];
                        sum_b      <= b_in[pick*W +: W];
                        sum_c      <= c_in[pick*W +: W];
                        win        <= pick;
                        gnt[pick]  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    res_data  <= sum_out;
                    res_id    <= win;
                    res_valid <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sum_arbiter.md
Name: sum_arbiter

Overview:
Round-robin scheduler that shares one combinational three-operand adder (the 4-bit a+b+c, 6-bit result `sum` block) between N_REQ requesters. It latches the winning requester's operands and drives them to the shared adder. It captures the adder result and returns it, tagged with the requester ID, through a valid/ready result port. It sits between the requester front-ends and the single `sum` instance.

Parameters:
N_REQ, 4, number of requesters (2..8); ID_W = $clog2(N_REQ) is a derived localparam.
W, 4, operand width; adder result width is W+2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  N_REQ  per-requester request; held high until that requester's gnt bit pulses.
a_in  input  N_REQ*W  operand a, requester i at bits [i*W +: W].
b_in  input  N_REQ*W  operand b, same packing.
c_in  input  N_REQ*W  operand c, same packing.
gnt  output  N_REQ  one-hot, 1-cycle pulse: operands of requester i were latched.
sum_a  output  W  registered operand to the shared adder's a.
sum_b  output  W  registered operand to the shared adder's b.
sum_c  output  W  registered operand to the shared adder's c.
sum_out  input  W+2  result from the shared adder.
res_valid  output  1  result available.
res_data  output  W+2  captured sum.
res_id  output  ID_W  index of the requester that owns res_data.
res_ready  input  1  consumer accepts the result.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer ptr=0.
  - gnt, sum_a/b/c, res_valid, res_data, res_id and busy all 0.
  - A reset in CALC or WAIT discards the transaction; the requester has already seen gnt and does not get a result.
- IDLE:
  - If no req bits are set, stay in IDLE.
  - Otherwise the winner is the first set req bit searching ptr, ptr+1, …, N_REQ-1, 0, …, wrapping modulo N_REQ.
  - On that clock edge: latch the winner's a/b/c into sum_a/b/c, latch the winner index into an internal win register, pulse gnt[win] for exactly one cycle, go to CALC.
- CALC:
  - Lasts one cycle so the combinational adder settles on the registered operands.
  - On the clock edge: res_data<=sum_out, res_id<=win, res_valid<=1, go to WAIT.
- WAIT:
  - res_valid, res_data, res_id and sum_a/b/c hold stable while res_ready=0.
  - When res_valid&&res_ready: res_valid<=0, ptr<=(win+1) mod N_REQ, go to IDLE.
  - res_ready sampled while res_valid=0 has no effect.
- Latency and throughput:
  - req high in IDLE -> gnt at edge 1, res_valid at edge 2.
  - Maximum rate is one transaction per 3 cycles when res_ready is tied high.
- Requester rules:
  - Operands must be stable while req is high.
  - A requester may drop req only after its gnt pulse; it may re-raise req on the cycle after gnt, but it will not win again until all others have had a chance.
  - A req dropped before being granted creates no transaction.
- Fairness: with all req bits held high, grant order is 0,1,2,3,0,… from reset; no requester waits more than N_REQ-1 transactions.
- Arithmetic: the result is the adder's full W+2-bit value with no truncation (max 3*(2^W-1) = 45 for W=4).
- busy is a registered/decoded state flag: 0 in IDLE, 1 in CALC and WAIT.

Test Plan:
1. Reset, then req=0001, a0=4, b0=5, c0=6 -> gnt=0001 for one cycle; two edges after the request is sampled, res_valid=1, res_data=15, res_id=0; res_ready=1 -> res_valid=0 next cycle, busy=0.
2. req=1111 held, res_ready=1, each requester i has a=b=c=i+1 -> gnt order 0,1,2,3,0 with a grant every 3 cycles; res_data sequence 3,6,9,12,3 and matching res_id.
3. Overflow width: a=b=c=15 on requester 2 -> res_data=45 (6'b101101), res_id=2.
4. Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid, res_data and res_id are stable; no gnt pulses while other req are pending; res_ready=1 -> accepted, and the next grant is issued from ptr=win+1.
5. Reset mid-operation: assert rst_n=0 in WAIT with res_valid=1 -> all outputs 0 immediately (asynchronous); after release with req=0100, the first gnt=0100 (ptr restarted at 0).
6. Late request: req=1000 granted, then req=0001 rises during CALC -> req[0] is granted in the next IDLE after acceptance, with the pointer wrapped to 0.
